// File: rtl/uart_handshake_responder.sv
// UART handshake responder: arms on listen, receives one byte, replies ACK or NAK
// and reports the outcome. Also holds the uart_rx / uart_tx engines it instantiates.

module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       reset_n,
  input  logic       i_Enable,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_BIT = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

  rx_state_t     state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    byte_r, byte_s;
  logic          dv_r, dv_s;
  logic          meta_r, sync_r;

  // Next-state logic; a disabled receiver is held idle so partial frames are dropped.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    byte_s  = byte_r;
    dv_s    = 1'b0;
    if (!i_Enable) begin
      state_s = RX_IDLE;
      cnt_s   = {CW{1'b0}};
      idx_s   = 3'd0;
    end else begin
      case (state_r)
        RX_IDLE: begin
          cnt_s   = {CW{1'b0}};
          idx_s   = 3'd0;
          state_s = sync_r ? RX_IDLE : RX_START;
        end
        RX_START: begin
          if (cnt_r == MID_BIT) begin
            cnt_s   = {CW{1'b0}};
            state_s = sync_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_END) begin
            cnt_s         = {CW{1'b0}};
            byte_s[idx_r] = sync_r;
            if (idx_r == 3'd7) begin
              state_s = RX_STOP;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_s   = {CW{1'b0}};
            dv_s    = 1'b1;
            state_s = RX_IDLE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        default: state_s = RX_IDLE;
      endcase
    end
  end

  // Line synchroniser and receiver state registers.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r  <= 1'b1;
      sync_r  <= 1'b1;
      state_r <= RX_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      byte_r  <= 8'h00;
      dv_r    <= 1'b0;
    end else begin
      meta_r  <= i_Rx_Serial;
      sync_r  <= meta_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      byte_r  <= byte_s;
      dv_r    <= dv_s;
    end
  end

  assign o_Rx_DV   = dv_r;
  assign o_Rx_Byte = byte_r;
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       i_Clock,
  input  logic       reset_n,
  input  logic       i_Enable,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;

  tx_state_t     state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    data_r, data_s;
  logic          serial_r, serial_s, done_r, done_s;

  // Next-state logic; dropping i_Enable aborts a frame and returns the line high.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    data_s  = data_r;
    done_s  = 1'b0;
    if (!i_Enable) begin
      state_s = TX_IDLE;
      cnt_s   = {CW{1'b0}};
      idx_s   = 3'd0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          cnt_s = {CW{1'b0}};
          idx_s = 3'd0;
          if (i_Tx_DV) begin
            data_s  = i_Tx_Byte;
            state_s = TX_START;
          end else begin
            state_s = TX_IDLE;
          end
        end
        TX_START, TX_DATA, TX_STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_s = {CW{1'b0}};
            if (state_r == TX_START) begin
              state_s = TX_DATA;
            end else if (state_r == TX_STOP) begin
              done_s  = 1'b1;
              state_s = TX_IDLE;
            end else if (idx_r == 3'd7) begin
              state_s = TX_STOP;
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        default: state_s = TX_IDLE;
      endcase
    end
    serial_s = 1'b1;
    case (state_s)
      TX_START: serial_s = 1'b0;
      TX_DATA:  serial_s = data_s[idx_s];
      default:  serial_s = 1'b1;
    endcase
  end

  // Transmitter state and registered line driver.
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= TX_IDLE;
      cnt_r    <= {CW{1'b0}};
      idx_r    <= 3'd0;
      data_r   <= 8'h00;
      serial_r <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      data_r   <= data_s;
      serial_r <= serial_s;
      done_r   <= done_s;
    end
  end

  assign o_Tx_Serial = serial_r;
  assign o_Tx_Done   = done_r;
endmodule

module uart_handshake_responder #(
  parameter int         CLKS_PER_BIT   = 5208,
  parameter logic [7:0] HS_BYTE        = 8'hFF,
  parameter logic [7:0] NAK_BYTE       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_Rx_Serial,
  input  logic       listen,
  input  logic       clear,
  output logic       o_Tx_Serial,
  output logic       handshake_active,
  output logic       handshake_done,
  output logic       handshake_successful,
  output logic       handshake_fail,
  output logic [3:0] handshake_code,
  output logic [7:0] rx_byte
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] CODE_NONE    = 4'b0000;
  localparam logic [3:0] CODE_OK      = 4'b1110;
  localparam logic [3:0] CODE_WRONG   = 4'b1111;
  localparam logic [3:0] CODE_TIMEOUT = 4'b1101;

  typedef enum logic [2:0] {
    IDLE = 3'd0, LISTEN = 3'd1, REPLY = 3'd2, WAIT_TX = 3'd3, DONE = 3'd4
  } hs_state_t;

  hs_state_t     state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [7:0]    tx_data_r, tx_data_s, rx_byte_r, rx_byte_s, rx_data_s;
  logic [3:0]    code_r, code_s;
  logic          tx_dv_r, tx_dv_s, match_r, match_s, ok_r, ok_s, fail_r, fail_s;
  logic          done_r, active_r, rx_dv_s, tx_done_s, tx_serial_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock(clock), .reset_n(reset_n), .i_Enable(active_r), .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV(rx_dv_s), .o_Rx_Byte(rx_data_s)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_Clock(clock), .reset_n(reset_n), .i_Enable(active_r), .i_Tx_DV(tx_dv_r),
    .i_Tx_Byte(tx_data_r), .o_Tx_Serial(tx_serial_s), .o_Tx_Done(tx_done_s)
  );

  // Handshake sequencing; reception beats the timeout when both land on one clock.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    tx_data_s = tx_data_r;
    rx_byte_s = rx_byte_r;
    match_s   = match_r;
    ok_s      = ok_r;
    fail_s    = fail_r;
    code_s    = code_r;
    if (clear) begin
      state_s = IDLE;
      timer_s = {TW{1'b0}};
      match_s = 1'b0;
      ok_s    = 1'b0;
      fail_s  = 1'b0;
      code_s  = CODE_NONE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (listen && !(state_r == DONE && fail_r)) begin
            state_s = LISTEN;
            timer_s = TIMER_LOAD;
            ok_s    = 1'b0;
            fail_s  = 1'b0;
            code_s  = CODE_NONE;
          end else begin
            state_s = state_r;
          end
        end
        LISTEN: begin
          if (rx_dv_s) begin
            rx_byte_s = rx_data_s;
            match_s   = (rx_data_s == HS_BYTE);
            tx_data_s = (rx_data_s == HS_BYTE) ? HS_BYTE : NAK_BYTE;
            state_s   = REPLY;
          end else if (timer_r == {TW{1'b0}}) begin
            state_s = DONE;
            ok_s    = 1'b0;
            fail_s  = 1'b1;
            code_s  = CODE_TIMEOUT;
          end else begin
            timer_s = timer_r - TW'(1);
          end
        end
        REPLY: state_s = WAIT_TX;
        WAIT_TX: begin
          if (tx_done_s) begin
            state_s = DONE;
            ok_s    = match_r;
            fail_s  = !match_r;
            code_s  = match_r ? CODE_OK : CODE_WRONG;
          end else begin
            state_s = WAIT_TX;
          end
        end
        default: state_s = IDLE;
      endcase
    end
    tx_dv_s = (state_s == REPLY);
  end

  // Handshake state and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      timer_r   <= {TW{1'b0}};
      tx_dv_r   <= 1'b0;
      tx_data_r <= 8'h00;
      rx_byte_r <= 8'h00;
      match_r   <= 1'b0;
      ok_r      <= 1'b0;
      fail_r    <= 1'b0;
      code_r    <= CODE_NONE;
      done_r    <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      tx_dv_r   <= tx_dv_s;
      tx_data_r <= tx_data_s;
      rx_byte_r <= rx_byte_s;
      match_r   <= match_s;
      ok_r      <= ok_s;
      fail_r    <= fail_s;
      code_r    <= code_s;
      done_r    <= (state_s == DONE);
      active_r  <= (state_s == LISTEN) || (state_s == REPLY) || (state_s == WAIT_TX);
    end
  end

  assign o_Tx_Serial          = (state_r == REPLY || state_r == WAIT_TX) ? tx_serial_s : 1'b1;
  assign handshake_active     = active_r;
  assign handshake_done       = done_r;
  assign handshake_successful = ok_r;
  assign handshake_fail       = fail_r;
  assign handshake_code       = code_r;
  assign rx_byte              = rx_byte_r;
endmodule

// File: tb/tb_uart_handshake_responder.sv
// Scoreboard bench for uart_handshake_responder: replies are decoded off o_Tx_Serial
// and matched against bytes queued when the stimulus was driven.

module tb_uart_handshake_responder;
  localparam int N = 8;
  // Start bit falls just after the LISTEN edge; o_Rx_DV is then seen 5+(N-1)/2+9N clocks later.
  localparam int EDGE_TIMEOUT = 5 + (N - 1) / 2 + 9 * N;

  logic clock, reset_n, rx_line, listen, listen_e, clear;
  logic tx, active, done, ok, fail;
  logic tx_e, active_e, done_e, ok_e, fail_e;
  logic [3:0] code, code_e;
  logic [7:0] rxb, rxb_e;
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  uart_handshake_responder #(.CLKS_PER_BIT(N), .TIMEOUT_CYCLES(1000)) dut (
    .clock(clock), .reset_n(reset_n), .i_Rx_Serial(rx_line), .listen(listen), .clear(clear),
    .o_Tx_Serial(tx), .handshake_active(active), .handshake_done(done),
    .handshake_successful(ok), .handshake_fail(fail), .handshake_code(code), .rx_byte(rxb)
  );

  uart_handshake_responder #(.CLKS_PER_BIT(N), .TIMEOUT_CYCLES(EDGE_TIMEOUT)) dut_edge (
    .clock(clock), .reset_n(reset_n), .i_Rx_Serial(rx_line), .listen(listen_e), .clear(clear),
    .o_Tx_Serial(tx_e), .handshake_active(active_e), .handshake_done(done_e),
    .handshake_successful(ok_e), .handshake_fail(fail_e), .handshake_code(code_e), .rx_byte(rxb_e)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_line = frame[k];
      repeat (N) @(posedge clock);
      #1;
    end
  endtask

  task automatic capture_frame(input bit sel, output logic [7:0] b, output bit seen);
    b = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if ((sel ? tx_e : tx) === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      repeat (N / 2) @(negedge clock);
      for (int k = 0; k < 8; k++) begin
        repeat (N) @(negedge clock);
        b[k] = sel ? tx_e : tx;
      end
      repeat (N) @(negedge clock);
    end
  endtask

  task automatic pulse_listen();
    listen = 1'b1;
    @(posedge clock);
    #1;
    listen = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; listen = 1'b0; listen_e = 1'b0; clear = 1'b0; rx_line = 1'b1;
    #3;
    checks++;
    if ({active, done, ok, fail, code, rxb, tx} !== {4'b0000, 4'b0000, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", {active, done, ok, fail, code, rxb, tx},
               {4'b0000, 4'b0000, 8'h00, 1'b1});
    end
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if ({active, done, ok, fail, code, tx, active_e, done_e, tx_e} !== {8'h00, 1'b1, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_idle got=%b required=%b",
               {active, done, ok, fail, code, tx, active_e, done_e, tx_e}, {8'h00, 1'b1, 2'b00, 1'b1});
    end
  endtask

  task automatic test_ack();
    logic [7:0] got, exp;
    bit seen;
    pulse_listen();
    checks++;
    if ({active, done, ok, fail} !== 4'b1000) begin
      errors++;
      $display("FAIL ack_listen_entry got=%b required=1000", {active, done, ok, fail});
    end
    exp_q.push_back(8'hFF);
    fork
      send_byte(8'hFF);
      capture_frame(1'b0, got, seen);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!seen || got !== exp) begin
      errors++;
      $display("FAIL ack_reply got=%h seen=%0d required=%h", got, seen, exp);
    end
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clock);
    @(posedge clock);
    #1;
    checks++;
    if ({done, ok, fail, code, rxb, tx} !== {3'b110, 4'b1110, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL ack_done got=%b required=%b", {done, ok, fail, code, rxb, tx},
               {3'b110, 4'b1110, 8'hFF, 1'b1});
    end
  endtask

  task automatic test_nak();
    logic [7:0] got, exp;
    bit seen;
    pulse_listen();
    checks++;
    if ({active, done, ok, fail, code} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL nak_rearm_from_done got=%b required=10000000", {active, done, ok, fail, code});
    end
    exp_q.push_back(8'h00);
    fork
      send_byte(8'hA5);
      capture_frame(1'b0, got, seen);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!seen || got !== exp) begin
      errors++;
      $display("FAIL nak_reply got=%h seen=%0d required=%h", got, seen, exp);
    end
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clock);
    @(posedge clock);
    #1;
    checks++;
    if ({done, ok, fail, code, rxb} !== {3'b101, 4'b1111, 8'hA5}) begin
      errors++;
      $display("FAIL nak_done got=%b required=%b", {done, ok, fail, code, rxb}, {3'b101, 4'b1111, 8'hA5});
    end
    pulse_listen();
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if ({active, done, fail, code} !== {3'b011, 4'b1111}) begin
      errors++;
      $display("FAIL nak_listen_ignored got=%b required=0111111", {active, done, fail, code});
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checks++;
    if ({active, done, ok, fail, code, rxb} !== {8'h00, 8'hA5}) begin
      errors++;
      $display("FAIL nak_clear got=%b required=%b", {active, done, ok, fail, code, rxb}, {8'h00, 8'hA5});
    end
    send_byte(8'h3C);
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if ({active, done, rxb, tx} !== {2'b00, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL idle_byte_ignored got=%b required=%b", {active, done, rxb, tx}, {2'b00, 8'hA5, 1'b1});
    end
  endtask

  task automatic test_timeout();
    int k;
    bit tx_low;
    tx_low = 1'b0;
    pulse_listen();
    for (k = 1; k <= 1100; k++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1) tx_low = 1'b1;
      if (done === 1'b1) break;
    end
    checks++;
    if (k != 1000) begin
      errors++;
      $display("FAIL timeout_latency got=%0d required=1000", k);
    end
    checks++;
    if ({ok, fail, code, tx_low} !== {2'b01, 4'b1101, 1'b0}) begin
      errors++;
      $display("FAIL timeout_flags got=%b required=0111010", {ok, fail, code, tx_low});
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_coincide();
    logic [7:0] got, exp;
    bit seen;
    listen_e = 1'b1;
    @(posedge clock);
    #1;
    listen_e = 1'b0;
    exp_q.push_back(8'hFF);
    fork
      send_byte(8'hFF);
      capture_frame(1'b1, got, seen);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!seen || got !== exp) begin
      errors++;
      $display("FAIL coincide_reply got=%h seen=%0d required=%h", got, seen, exp);
    end
    for (int i = 0; i < 300 && done_e !== 1'b1; i++) @(negedge clock);
    @(posedge clock);
    #1;
    checks++;
    if ({active_e, done_e, ok_e, fail_e, code_e, rxb_e} !== {4'b0110, 4'b1110, 8'hFF}) begin
      errors++;
      $display("FAIL coincide_done got=%b required=%b", {active_e, done_e, ok_e, fail_e, code_e, rxb_e},
               {4'b0110, 4'b1110, 8'hFF});
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    bit tx_low;
    bit woke;
    pulse_listen();
    fork
      send_byte(8'hFF);
      begin
        for (int i = 0; i < 300 && tx !== 1'b0; i++) @(negedge clock);
        repeat (20) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx, active, done, ok, fail, code, rxb} !== {1'b1, 8'h00, 8'h00}) begin
          errors++;
          $display("FAIL reset_mid_tx got=%b required=%b", {tx, active, done, ok, fail, code, rxb},
                   {1'b1, 8'h00, 8'h00});
        end
      end
    join
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tx_low = 1'b0;
    woke = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1) tx_low = 1'b1;
      if (active !== 1'b0 || done !== 1'b0) woke = 1'b1;
    end
    checks++;
    if ({tx_low, woke} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stays_idle got=%b required=00", {tx_low, woke});
    end
  endtask

  task automatic test_clear_wait_tx();
    logic [7:0] got, exp;
    bit seen;
    pulse_listen();
    fork
      send_byte(8'hFF);
      for (int i = 0; i < 300 && tx !== 1'b0; i++) @(negedge clock);
    join
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL clear_reply_start got=%b required=0", tx);
    end
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checks++;
    if ({tx, active, done, ok, fail, code, rxb} !== {1'b1, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL clear_wait_tx got=%b required=%b", {tx, active, done, ok, fail, code, rxb},
               {1'b1, 8'h00, 8'hFF});
    end
    repeat (20) @(posedge clock);
    #1;
    pulse_listen();
    exp_q.push_back(8'hFF);
    fork
      send_byte(8'hFF);
      capture_frame(1'b0, got, seen);
    join
    exp = exp_q.pop_front();
    checks++;
    if (!seen || got !== exp) begin
      errors++;
      $display("FAIL clear_rearm_reply got=%h seen=%0d required=%h", got, seen, exp);
    end
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clock);
    @(posedge clock);
    #1;
    checks++;
    if ({done, ok, fail, code} !== {3'b110, 4'b1110}) begin
      errors++;
      $display("FAIL clear_rearm_done got=%b required=1101110", {done, ok, fail, code});
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak();
    test_timeout();
    test_coincide();
    test_reset_mid_tx();
    test_clear_wait_tx();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
